// File: rtl/arbiter_wrr.sv
// Weighted round-robin arbiter: one owner at a time, each holding the grant
// for up to its programmed weight in cycles before rotating to the next requester.
module arbiter_wrr #(
   parameter int unsigned NUM_PORTS = 8,
   parameter int unsigned WEIGHT_W  = 4,
   parameter int unsigned ID_W      = 3
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [NUM_PORTS-1:0]            request,
   input  logic [NUM_PORTS*WEIGHT_W-1:0]   weight,
   output logic [NUM_PORTS-1:0]            grant,
   output logic [ID_W-1:0]                 grant_id,
   output logic                            active,
   output logic [WEIGHT_W-1:0]             quota
);

   typedef enum logic {IDLE, OWNED} state_t;

   state_t                state, state_nxt;
   logic [ID_W-1:0]       ptr, ptr_nxt;
   logic [NUM_PORTS-1:0]  grant_nxt;
   logic [ID_W-1:0]       id_nxt;
   logic [WEIGHT_W-1:0]   quota_nxt;

   logic [WEIGHT_W-1:0]   w_arr [NUM_PORTS];
   logic                  sel_found;
   logic [ID_W-1:0]       sel_id;
   logic [ID_W-1:0]       cand;
   logic [WEIGHT_W-1:0]   sel_load;
   logic [WEIGHT_W-1:0]   own_load;

   // Unpack per-port weights.
   always_comb begin
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
         w_arr[p] = weight[p*WEIGHT_W +: WEIGHT_W];
      end
   end

   // Round-robin search starting just after the pointer; the owner is searched last.
   always_comb begin
      sel_found = 1'b0;
      sel_id    = '0;
      cand      = '0;
      for (int unsigned i = 1; i <= NUM_PORTS; i++) begin
         cand = ID_W'((32'(ptr) + i) % NUM_PORTS);
         if (!sel_found && request[cand]) begin
            sel_found = 1'b1;
            sel_id    = cand;
         end
      end
   end

   // A zero weight still grants one cycle.
   assign sel_load = (w_arr[sel_id]   == '0) ? WEIGHT_W'(1) : w_arr[sel_id];
   assign own_load = (w_arr[grant_id] == '0) ? WEIGHT_W'(1) : w_arr[grant_id];

   always_comb begin
      state_nxt = state;
      grant_nxt = grant;
      id_nxt    = grant_id;
      quota_nxt = quota;
      ptr_nxt   = ptr;
      unique case (state)
         IDLE: begin
            if (sel_found) begin
               state_nxt = OWNED;
               grant_nxt = NUM_PORTS'(1) << sel_id;
               id_nxt    = sel_id;
               quota_nxt = sel_load;
               ptr_nxt   = sel_id;
            end
         end
         OWNED: begin
            if (!request[grant_id] || (quota == WEIGHT_W'(1) && sel_id != grant_id)) begin
               // Release or rotate; owner request low means it cannot be re-selected.
               if (sel_found) begin
                  grant_nxt = NUM_PORTS'(1) << sel_id;
                  id_nxt    = sel_id;
                  quota_nxt = sel_load;
                  ptr_nxt   = sel_id;
               end else begin
                  state_nxt = IDLE;
                  grant_nxt = '0;
                  id_nxt    = '0;
                  quota_nxt = '0;
               end
            end else if (quota > WEIGHT_W'(1)) begin
               quota_nxt = quota - WEIGHT_W'(1);
            end else begin
               quota_nxt = own_load;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         ptr      <= ID_W'(NUM_PORTS - 1);
         grant    <= '0;
         grant_id <= '0;
         quota    <= '0;
         active   <= 1'b0;
      end else begin
         state    <= state_nxt;
         ptr      <= ptr_nxt;
         grant    <= grant_nxt;
         grant_id <= id_nxt;
         quota    <= quota_nxt;
         active   <= |grant_nxt;
      end
   end

endmodule

// File: tb/tb_arbiter_wrr.sv
// Directed bench for arbiter_wrr: hand-computed grant/grant_id/quota after each edge.
module tb_arbiter_wrr;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  request;
   logic [31:0] weight;
   logic [7:0]  grant;
   logic [2:0]  grant_id;
   logic        active;
   logic [3:0]  quota;

   int checks = 0;
   int errors = 0;

   arbiter_wrr #(.NUM_PORTS(8), .WEIGHT_W(4), .ID_W(3)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .request  (request),
      .weight   (weight),
      .grant    (grant),
      .grant_id (grant_id),
      .active   (active),
      .quota    (quota)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_w(input int p, input int v);
      weight[p*4 +: 4] = 4'(v);
   endtask

   task automatic check(input string tag, input logic [7:0] eg, input logic [2:0] eid,
                        input logic [3:0] eq);
      logic ea;
      ea = (eg != 8'h00);
      checks++;
      assert (grant === eg) else begin
         errors++;
         $error("FAIL %s grant got %h exp %h", tag, grant, eg);
      end
      checks++;
      assert (grant_id === eid) else begin
         errors++;
         $error("FAIL %s grant_id got %0d exp %0d", tag, grant_id, eid);
      end
      checks++;
      assert (quota === eq) else begin
         errors++;
         $error("FAIL %s quota got %0d exp %0d", tag, quota, eq);
      end
      checks++;
      assert (active === ea) else begin
         errors++;
         $error("FAIL %s active got %b exp %b", tag, active, ea);
      end
   endtask

   initial begin
      rst_n   = 1'b0;
      request = 8'hFF;
      weight  = 32'h1111_1111;

      // Reset held with every port requesting
      for (int i = 0; i < 5; i++) begin
         tick();
         check("reset", 8'h00, 3'd0, 4'd0);
      end

      // Port 0 first, then alternation with port 7
      rst_n   = 1'b1;
      request = 8'h81;
      tick(); check("lat0", 8'h01, 3'd0, 4'd1);
      tick(); check("alt1", 8'h80, 3'd7, 4'd1);
      tick(); check("alt2", 8'h01, 3'd0, 4'd1);
      tick(); check("alt3", 8'h80, 3'd7, 4'd1);
      request = 8'h00;
      tick(); check("idle1", 8'h00, 3'd0, 4'd0);

      // Weighting 3:1
      set_w(0, 3);
      set_w(1, 1);
      request = 8'h03;
      tick(); check("wt_a", 8'h01, 3'd0, 4'd3);
      tick(); check("wt_b", 8'h01, 3'd0, 4'd2);
      tick(); check("wt_c", 8'h01, 3'd0, 4'd1);
      tick(); check("wt_d", 8'h02, 3'd1, 4'd1);
      tick(); check("wt_e", 8'h01, 3'd0, 4'd3);
      request = 8'h00;
      tick(); check("idle2", 8'h00, 3'd0, 4'd0);

      // Early release hands over without an idle cycle
      set_w(2, 5);
      request = 8'h04;
      tick(); check("er_a", 8'h04, 3'd2, 4'd5);
      tick(); check("er_b", 8'h04, 3'd2, 4'd4);
      request = 8'h20;
      tick(); check("er_hand", 8'h20, 3'd5, 4'd1);

      // Sole requester keeps grant, quota reloads from new weight
      set_w(5, 2);
      tick(); check("sole_a", 8'h20, 3'd5, 4'd2);
      tick(); check("sole_b", 8'h20, 3'd5, 4'd1);
      tick(); check("sole_c", 8'h20, 3'd5, 4'd2);
      // New request does not preempt; rotates only when quota expires
      request = 8'h21;
      tick(); check("nopre", 8'h20, 3'd5, 4'd1);
      tick(); check("rot", 8'h01, 3'd0, 4'd3);

      // Weight 0 loads as 1, then reset mid-grant
      set_w(3, 0);
      request = 8'h08;
      tick(); check("w0_a", 8'h08, 3'd3, 4'd1);
      tick(); check("w0_b", 8'h08, 3'd3, 4'd1);
      rst_n = 1'b0;
      tick(); check("rst_mid", 8'h00, 3'd0, 4'd0);
      rst_n   = 1'b1;
      request = 8'h09;
      tick(); check("post_rst", 8'h01, 3'd0, 4'd3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
